// File: rtl/alu_seq_ctrl.sv
// Sequencer that fetches 32-bit instructions from a small program memory and drives an external ALU.
// Optional single-step FETCH gating is enabled by defining ALU_SEQ_STEP_EN.
module alu_seq_ctrl #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned IMEM_DEPTH = 16,
   parameter int unsigned MAX_INSTR  = 255
) (
   input  logic              clkout,
   input  logic              rst_n,
   input  logic              start,
`ifdef ALU_SEQ_STEP_EN
   input  logic              step,
`endif
   input  logic              prog_we,
   input  logic [3:0]        prog_addr,
   input  logic [31:0]       prog_data,
   output logic [7:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] alu_val,
   output logic              alu_cin,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [4:0]        alu_flags,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [3:0]        pc_dbg,
   output logic [4:0]        flags_q
);

   localparam int unsigned CntW = $clog2(MAX_INSTR + 1);

   localparam logic [7:0] OpHlt = 8'd0;
   localparam logic [7:0] OpNop = 8'd1;
   localparam logic [7:0] OpJmp = 8'd2;
   localparam logic [7:0] OpJz  = 8'd3;
   localparam logic [7:0] OpJc  = 8'd4;
   localparam logic [7:0] OpMvi = 8'd5;

   typedef enum logic [2:0] {StIdle, StFetch, StExec, StWait, StWb} state_e;

   state_e            state_q, state_d;
   logic [3:0]        pc_q, pc_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic [4:0]        lat_flags_q, lat_flags_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] rf_q [16];
   logic [31:0]       imem_q [IMEM_DEPTH];

   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;
   logic              imem_we;
   logic              retire;
   logic              fetch_go;
   logic              alu_phase;
   logic [7:0]        op;
   logic [3:0]        rd, rs;
   logic [DATA_W-1:0] imm_sext;
   logic              is_alu;

`ifdef ALU_SEQ_STEP_EN
   assign fetch_go = step;
`else
   assign fetch_go = 1'b1;
`endif

   assign op       = ir_q[31:24];
   assign rd       = ir_q[23:20];
   assign rs       = ir_q[19:16];
   assign imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
   assign is_alu   = (op >= 8'd29) && (op <= 8'd44);
   assign imem_we  = (state_q == StIdle) && prog_we;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      done_d      = 1'b0;
      lat_flags_d = lat_flags_q;
      ir_d        = ir_q;
      rf_we       = 1'b0;
      rf_wdata    = alu_result;
      retire      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
               pc_d    = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         StFetch: begin
            if (fetch_go) begin
               ir_d    = imem_q[pc_q];
               state_d = StExec;
            end
         end
         StExec: begin
            if (is_alu) begin
               state_d = StWait;
            end else begin
               retire  = 1'b1;
               state_d = StFetch;
               pc_d    = pc_q + 4'd1;
               case (op)
                  OpHlt: begin
                     pc_d    = pc_q;
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end
                  OpNop: ;
                  OpJmp: pc_d = ir_q[3:0];
                  OpJz:  if (lat_flags_q[4]) pc_d = ir_q[3:0];
                  OpJc:  if (lat_flags_q[3]) pc_d = ir_q[3:0];
                  OpMvi: begin
                     rf_we    = 1'b1;
                     rf_wdata = imm_sext;
                  end
                  default: begin
                     retire  = 1'b0;
                     pc_d    = pc_q;
                     err_d   = 1'b1;
                     state_d = StIdle;
                  end
               endcase
            end
         end
         StWait: state_d = StWb;
         StWb: begin
            rf_we       = 1'b1;
            lat_flags_d = alu_flags;
            pc_d        = pc_q + 4'd1;
            retire      = 1'b1;
            state_d     = StFetch;
         end
         default: state_d = StIdle;
      endcase
      // Watchdog: the instruction that reaches the limit still completes, then the run stops.
      if (retire) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CntW'(MAX_INSTR)) begin
            err_d   = 1'b1;
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clkout or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         lat_flags_q <= '0;
         ir_q        <= '0;
         for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         done_q      <= done_d;
         lat_flags_q <= lat_flags_d;
         ir_q        <= ir_d;
         if (rf_we) rf_q[rd] <= rf_wdata;
      end
   end

   // Program memory keeps its contents across reset.
   always_ff @(posedge clkout) begin
      if (imem_we) imem_q[prog_addr] <= prog_data;
   end

   assign alu_phase  = ((state_q == StExec) && is_alu) || (state_q == StWait) || (state_q == StWb);
   assign alu_opcode = alu_phase ? op : 8'hFF;
   assign alu_a      = alu_phase ? rf_q[0] : '0;
   assign alu_b      = alu_phase ? rf_q[rs] : '0;
   assign alu_val    = alu_phase ? imm_sext : '0;
   assign alu_cin    = alu_phase ? lat_flags_q[3] : 1'b0;

   assign busy    = (state_q != StIdle);
   assign done    = done_q;
   assign err     = err_q;
   assign pc_dbg  = pc_q;
   assign flags_q = lat_flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: a behavioural ALU answers the DUT, expected ALU transactions
// and end-of-run states are queued by the stimulus and popped by a monitor.
module tb_alu_seq_ctrl;

   logic        clkout = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [31:0] prog_data = '0;
   logic [7:0]  alu_opcode;
   logic [31:0] alu_a, alu_b, alu_val, alu_result;
   logic        alu_cin;
   logic [4:0]  alu_flags;
   logic        busy, done, err;
   logic [3:0]  pc_dbg;
   logic [4:0]  flags_q;
`ifdef ALU_SEQ_STEP_EN
   logic        step = 1'b1;
`endif

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] a, b, v;
      logic        cin;
      int unsigned hold;
   } txn_t;

   typedef struct {
      logic        done, err;
      logic [3:0]  pc;
      logic [4:0]  fl;
      int unsigned cyc;
      bit          chk_cyc;
   } end_t;

   txn_t alu_q[$];
   end_t end_q[$];

   alu_seq_ctrl dut (
      .clkout    (clkout),
      .rst_n     (rst_n),
      .start     (start),
`ifdef ALU_SEQ_STEP_EN
      .step      (step),
`endif
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .alu_opcode(alu_opcode),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_val   (alu_val),
      .alu_cin   (alu_cin),
      .alu_result(alu_result),
      .alu_flags (alu_flags),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .pc_dbg    (pc_dbg),
      .flags_q   (flags_q)
   );

   always #5 clkout = ~clkout;

   // Behavioural ALU: 29 = ADA (a+b), 31 = SBA (a-b, C = borrow), others xor; flags {Z,C,S,P,V}.
   logic [32:0] alu_sum;
   always_comb begin
      alu_sum = '0;
      case (alu_opcode)
         8'd29:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
         8'd31:   alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
         default: alu_sum = {1'b0, alu_a ^ alu_b};
      endcase
      alu_result = alu_sum[31:0];
      alu_flags  = {(alu_sum[31:0] == 32'd0), alu_sum[32], alu_sum[31], 1'b0, 1'b0};
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic summary();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   endtask

   function automatic logic [31:0] ins(input logic [7:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [15:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic push_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] v, input logic cin, input int unsigned hold);
      txn_t t;
      t.op = op; t.a = a; t.b = b; t.v = v; t.cin = cin; t.hold = hold;
      alu_q.push_back(t);
   endtask

   task automatic push_end(input logic dn, input logic er, input logic [3:0] pc,
                           input logic [4:0] fl, input int unsigned cyc, input bit chk_cyc);
      end_t e;
      e.done = dn; e.err = er; e.pc = pc; e.fl = fl; e.cyc = cyc; e.chk_cyc = chk_cyc;
      end_q.push_back(e);
   endtask

   task automatic prog(input logic [3:0] a, input logic [31:0] w);
      @(negedge clkout);
      prog_we = 1'b1; prog_addr = a; prog_data = w;
      @(negedge clkout);
      prog_we = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned max_cyc);
      int unsigned n = 0;
      while (busy && n < max_cyc) begin
         @(negedge clkout);
         n++;
      end
      chk("run_timeout", busy, 1'b0);
      if (busy) summary();
      @(negedge clkout);
   endtask

   // Start a run; optionally write imem in the start cycle, and optionally poke start/prog_we
   // while busy (both must be ignored).
   task automatic go(input bit we, input logic [3:0] a, input logic [31:0] w, input bit poke);
      @(negedge clkout);
      start = 1'b1;
      if (we) begin prog_we = 1'b1; prog_addr = a; prog_data = w; end
      @(negedge clkout);
      start = 1'b0; prog_we = 1'b0;
      if (poke) begin
         @(negedge clkout);
         start = 1'b1; prog_we = 1'b1; prog_addr = 4'd1; prog_data = ins(8'h77, 0, 0, 0);
         @(negedge clkout);
         start = 1'b0; prog_we = 1'b0;
      end
      wait_idle(2000);
   endtask

   // Monitor: ALU transactions, end-of-run state and done pulse width.
   initial begin : monitor
      txn_t        cur;
      end_t        e;
      bit          in_txn = 1'b0;
      bit          prev_busy = 1'b0;
      bit          dchk = 1'b0;
      int unsigned hold = 0;
      int unsigned bcyc = 0;
      cur = '{op: 8'h00, a: 32'h0, b: 32'h0, v: 32'h0, cin: 1'b0, hold: 0};
      forever begin
         @(negedge clkout);
         if (dchk) begin
            chk("done_width", done, 1'b0);
            dchk = 1'b0;
         end
         if (alu_opcode != 8'hFF) begin
            if (!in_txn) begin
               in_txn = 1'b1;
               hold = 0;
               chk("alu_txn_expected", (alu_q.size() != 0), 1'b1);
               if (alu_q.size() != 0) cur = alu_q.pop_front();
            end
            hold++;
            chk("alu_opcode", alu_opcode, cur.op);
            chk("alu_a", alu_a, cur.a);
            chk("alu_b", alu_b, cur.b);
            chk("alu_val", alu_val, cur.v);
            chk("alu_cin", alu_cin, cur.cin);
         end else if (in_txn) begin
            in_txn = 1'b0;
            chk("alu_hold_cycles", hold, cur.hold);
         end
         if (busy) bcyc++;
         if (prev_busy && !busy) begin
            chk("end_expected", (end_q.size() != 0), 1'b1);
            if (end_q.size() != 0) begin
               e = end_q.pop_front();
               chk("end_done", done, e.done);
               chk("end_err", err, e.err);
               chk("end_pc", pc_dbg, e.pc);
               chk("end_flags", flags_q, e.fl);
               if (e.chk_cyc) chk("busy_cycles", bcyc, e.cyc);
            end
            bcyc = 0;
            dchk = 1'b1;
         end
         prev_busy = busy;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clkout);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_pc", pc_dbg, 4'd0);
      chk("rst_flags", flags_q, 5'd0);
      chk("rst_opcode", alu_opcode, 8'hFF);
      chk("rst_a", alu_a, 32'd0);
      chk("rst_b", alu_b, 32'd0);
      chk("rst_val", alu_val, 32'd0);
      chk("rst_cin", alu_cin, 1'b0);
      rst_n = 1'b1;

      // 5 + 3 -> R2, read R2 back through alu_b, halt.
      prog(4'd0, ins(8'd5, 4'd0, 4'd0, 16'd5));
      prog(4'd1, ins(8'd5, 4'd1, 4'd0, 16'd3));
      prog(4'd2, ins(8'd29, 4'd2, 4'd1, 16'd0));
      prog(4'd3, ins(8'd29, 4'd3, 4'd2, 16'd0));
      prog(4'd4, ins(8'd0, 4'd0, 4'd0, 16'd0));
      push_txn(8'd29, 32'd5, 32'd3, 32'd0, 1'b0, 3);
      push_txn(8'd29, 32'd5, 32'd8, 32'd0, 1'b0, 3);
      push_end(1'b1, 1'b0, 4'd4, 5'b00000, 14, 1'b1);
      go(1'b0, 4'd0, 32'd0, 1'b0);

      // 0 - 0 sets Z, JZ 6 taken.
      prog(4'd0, ins(8'd5, 4'd0, 4'd0, 16'd0));
      prog(4'd1, ins(8'd5, 4'd1, 4'd0, 16'd0));
      prog(4'd2, ins(8'd31, 4'd3, 4'd1, 16'd0));
      prog(4'd3, ins(8'd3, 4'd0, 4'd0, 16'd6));
      prog(4'd4, ins(8'h77, 4'd0, 4'd0, 16'd0));
      prog(4'd6, ins(8'd0, 4'd0, 4'd0, 16'd0));
      push_txn(8'd31, 32'd0, 32'd0, 32'd0, 1'b0, 3);
      push_end(1'b1, 1'b0, 4'd6, 5'b10000, 12, 1'b1);
      go(1'b0, 4'd0, 32'd0, 1'b0);

      // 0 - 1 borrows, JC 7 taken, ADA shows cin=1 and sign-extended imm.
      prog(4'd1, ins(8'd5, 4'd1, 4'd0, 16'd1));
      prog(4'd3, ins(8'd4, 4'd0, 4'd0, 16'd7));
      prog(4'd7, ins(8'd29, 4'd4, 4'd3, 16'h8001));
      prog(4'd8, ins(8'd0, 4'd0, 4'd0, 16'd0));
      push_txn(8'd31, 32'd0, 32'd1, 32'd0, 1'b0, 3);
      push_txn(8'd29, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_8001, 1'b1, 3);
      push_end(1'b1, 1'b0, 4'd8, 5'b00100, 16, 1'b1);
      go(1'b0, 4'd0, 32'd0, 1'b0);

      // Illegal opcode at PC 0.
      prog(4'd0, ins(8'h77, 4'd0, 4'd0, 16'd0));
      push_end(1'b0, 1'b1, 4'd0, 5'b00100, 2, 1'b1);
      go(1'b0, 4'd0, 32'd0, 1'b0);

      // Write imem[0] in the start cycle; start/prog_we while busy are ignored; err cleared.
      prog(4'd1, ins(8'd0, 4'd0, 4'd0, 16'd0));
      push_txn(8'd29, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 3);
      push_end(1'b1, 1'b0, 4'd1, 5'b00100, 6, 1'b1);
      go(1'b1, 4'd0, ins(8'd29, 4'd6, 4'd4, 16'd0), 1'b1);

      // JMP 0 forever: watchdog after 255 instructions.
      prog(4'd0, ins(8'd2, 4'd0, 4'd0, 16'd0));
      push_end(1'b0, 1'b1, 4'd0, 5'b00100, 510, 1'b1);
      go(1'b0, 4'd0, 32'd0, 1'b0);

      // Reset during WAIT of an ADA that would write R0.
      prog(4'd0, ins(8'd29, 4'd0, 4'd4, 16'd0));
      push_txn(8'd29, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 2);
      push_end(1'b0, 1'b0, 4'd0, 5'b00000, 3, 1'b1);
      @(negedge clkout);
      start = 1'b1;
      @(negedge clkout);
      start = 1'b0;
      repeat (2) @(negedge clkout);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clkout);
      chk("abort_busy", busy, 1'b0);
      chk("abort_pc", pc_dbg, 4'd0);
      chk("abort_opcode", alu_opcode, 8'hFF);
      rst_n = 1'b1;
      // Same program reruns from PC 0: memory survived, registers were cleared.
      push_txn(8'd29, 32'd0, 32'd0, 32'd0, 1'b0, 3);
      push_end(1'b1, 1'b0, 4'd1, 5'b10000, 6, 1'b1);
      go(1'b0, 4'd0, 32'd0, 1'b0);

      // PC wraps 15 -> 0; JZ not taken afterwards.
      prog(4'd0, ins(8'd3, 4'd0, 4'd0, 16'd14));
      prog(4'd14, ins(8'd5, 4'd1, 4'd0, 16'd1));
      prog(4'd15, ins(8'd31, 4'd0, 4'd1, 16'd0));
      push_txn(8'd31, 32'd0, 32'd1, 32'd0, 1'b0, 3);
      push_end(1'b1, 1'b0, 4'd1, 5'b01100, 12, 1'b1);
      go(1'b0, 4'd0, 32'd0, 1'b0);

`ifdef ALU_SEQ_STEP_EN
      // Three step pulses, ten cycles apart, execute exactly three NOPs.
      step = 1'b0;
      for (int i = 0; i < 4; i++) prog(4'(i), ins(8'd1, 4'd0, 4'd0, 16'd0));
      prog(4'd4, ins(8'd0, 4'd0, 4'd0, 16'd0));
      @(negedge clkout);
      start = 1'b1;
      @(negedge clkout);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clkout);
         step = 1'b1;
         @(negedge clkout);
         step = 1'b0;
         repeat (8) @(negedge clkout);
      end
      chk("step_pc", pc_dbg, 4'd3);
      chk("step_busy", busy, 1'b1);
      push_end(1'b1, 1'b0, 4'd4, 5'b01100, 0, 1'b0);
      step = 1'b1;
      wait_idle(100);
`endif

      chk("alu_q_empty", alu_q.size(), 0);
      chk("end_q_empty", end_q.size(), 0);
      summary();
   end

endmodule
